// File: rtl/csr_wr_seq_pkg.sv
// Shared constants and helpers for the CSR write sequencer.
// Holds CSR addresses, the FSM encoding and the pending-mask pick helpers.
package csr_wr_seq_pkg;

  localparam int CSR_DW = 32;
  localparam int CSR_AW = 12;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  // Pending-mask bit positions; the lowest set bit is written first.
  localparam int BIT_MEPC    = 0;
  localparam int BIT_MCAUSE  = 1;
  localparam int BIT_MSTATUS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_CSR  = 2'd2
  } state_t;

  // Isolate the lowest set bit of the pending mask (one-hot or zero).
  function automatic logic [2:0] lowest_one(input logic [2:0] mask);
    return mask & (~mask + 3'd1);
  endfunction

  function automatic logic [11:0] pick_addr(input logic [2:0] pick);
    logic [11:0] addr;
    addr = 12'h000;
    if (pick[BIT_MEPC])         addr = CSR_MEPC;
    else if (pick[BIT_MCAUSE])  addr = CSR_MCAUSE;
    else if (pick[BIT_MSTATUS]) addr = CSR_MSTATUS;
    return addr;
  endfunction

endpackage

// File: rtl/csr_wr_seq_stdreg.sv
// Plain enable register with asynchronous active-low reset to zero.
module csr_wr_seq_stdreg #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wen,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   o_q <= '0;
    else if (i_wen) o_q <= i_d;
  end

endmodule

// File: rtl/csr_wr_seq.sv
// Serialises trap-writeback and instruction CSR writes onto one CSR-file write port.
// Trap bundle wins collisions; o_done pulses in the cycle of the last write of a request.
module csr_wr_seq
  import csr_wr_seq_pkg::*;
#(
  parameter int DW = CSR_DW,
  parameter int AW = CSR_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_trap_valid,
  output logic          o_trap_ready,
  input  logic          i_mepc_wen,
  input  logic [DW-1:0] i_mepc_wdata,
  input  logic          i_mcause_wen,
  input  logic [DW-1:0] i_mcause_wdata,
  input  logic          i_mstatus_wen,
  input  logic [DW-1:0] i_mstatus_wdata,
  input  logic          i_csr_valid,
  output logic          o_csr_ready,
  input  logic [AW-1:0] i_csr_addr,
  input  logic [DW-1:0] i_csr_wdata,
  output logic          o_wen,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_done,
  output logic          o_busy
);

  state_t        state;
  logic [2:0]    pending;
  logic [DW-1:0] mcause_q;
  logic [DW-1:0] mstatus_q;

  logic          trap_acc;
  logic          csr_acc;
  logic [2:0]    src_mask;
  logic [2:0]    pick;
  logic [2:0]    rest;
  logic [DW-1:0] pick_data;

  assign o_trap_ready = (state == ST_IDLE);
  assign o_csr_ready  = (state == ST_IDLE) & ~i_trap_valid;
  assign o_busy       = (state != ST_IDLE);
  assign trap_acc     = i_trap_valid & o_trap_ready;
  assign csr_acc      = i_csr_valid & o_csr_ready;

  // mepc is always the first write when enabled, so it is taken straight from the
  // bundle on the accept edge and never needs a latched copy.
  csr_wr_seq_stdreg #(.W(DW)) u_mcause_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (trap_acc),
    .i_d     (i_mcause_wdata),
    .o_q     (mcause_q)
  );

  csr_wr_seq_stdreg #(.W(DW)) u_mstatus_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wen   (trap_acc),
    .i_d     (i_mstatus_wdata),
    .o_q     (mstatus_q)
  );

  // On the accept edge the first write is chosen from the live bundle; afterwards
  // only the latched copies feed the write port.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_mask  = pending;
    pick_data = '0;
    if (state == ST_IDLE)
      src_mask = {i_mstatus_wen, i_mcause_wen, i_mepc_wen};
    pick = lowest_one(src_mask);
    rest = src_mask & ~pick;
    if (pick[BIT_MEPC])
      pick_data = i_mepc_wdata;
    else if (pick[BIT_MCAUSE])
      pick_data = (state == ST_IDLE) ? i_mcause_wdata : mcause_q;
    else if (pick[BIT_MSTATUS])
      pick_data = (state == ST_IDLE) ? i_mstatus_wdata : mstatus_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_done  <= 1'b0;
    end else begin
      o_wen   <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trap_acc) begin
            state   <= ST_TRAP;
            pending <= rest;
            o_wen   <= |pick;
            o_waddr <= AW'(pick_addr(pick));
            o_wdata <= pick_data;
            o_done  <= (rest == 3'b000);
          end else if (csr_acc) begin
            state   <= ST_CSR;
            o_wen   <= 1'b1;
            o_waddr <= i_csr_addr;
            o_wdata <= i_csr_wdata;
            o_done  <= 1'b1;
          end
        end
        ST_TRAP: begin
          // pending holds only writes not yet presented on the port.
          if (pending == 3'b000) begin
            state <= ST_IDLE;
          end else begin
            pending <= rest;
            o_wen   <= 1'b1;
            o_waddr <= AW'(pick_addr(pick));
            o_wdata <= pick_data;
            o_done  <= (rest == 3'b000);
          end
        end
        ST_CSR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_wr_seq.sv
// Table-driven bench for csr_wr_seq: per-cycle input/expected-output rows plus
// a hand-written mid-sequence reset scenario.
module tb_csr_wr_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_trap_valid;
  logic        o_trap_ready;
  logic        i_mepc_wen;
  logic [31:0] i_mepc_wdata;
  logic        i_mcause_wen;
  logic [31:0] i_mcause_wdata;
  logic        i_mstatus_wen;
  logic [31:0] i_mstatus_wdata;
  logic        i_csr_valid;
  logic        o_csr_ready;
  logic [11:0] i_csr_addr;
  logic [31:0] i_csr_wdata;
  logic        o_wen;
  logic [11:0] o_waddr;
  logic [31:0] o_wdata;
  logic        o_done;
  logic        o_busy;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  csr_wr_seq dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_trap_valid    (i_trap_valid),
    .o_trap_ready    (o_trap_ready),
    .i_mepc_wen      (i_mepc_wen),
    .i_mepc_wdata    (i_mepc_wdata),
    .i_mcause_wen    (i_mcause_wen),
    .i_mcause_wdata  (i_mcause_wdata),
    .i_mstatus_wen   (i_mstatus_wen),
    .i_mstatus_wdata (i_mstatus_wdata),
    .i_csr_valid     (i_csr_valid),
    .o_csr_ready     (o_csr_ready),
    .i_csr_addr      (i_csr_addr),
    .i_csr_wdata     (i_csr_wdata),
    .o_wen           (o_wen),
    .o_waddr         (o_waddr),
    .o_wdata         (o_wdata),
    .o_done          (o_done),
    .o_busy          (o_busy)
  );

  typedef struct packed {
    logic        trap_valid;
    logic [2:0]  wens;        // {mstatus, mcause, mepc}
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mstatus;
    logic        csr_valid;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } in_t;

  typedef struct packed {
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        done;
    logic        busy;
    logic        trap_ready;
    logic        csr_ready;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];

  function automatic in_t mk_in(logic tv, logic [2:0] w, logic [31:0] a, logic [31:0] b,
                                logic [31:0] c, logic cv, logic [11:0] ca, logic [31:0] cd);
    in_t r;
    r = '{trap_valid: tv, wens: w, mepc: a, mcause: b, mstatus: c,
          csr_valid: cv, csr_addr: ca, csr_wdata: cd};
    return r;
  endfunction

  function automatic in_t in_idle();
    return mk_in(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
  endfunction

  function automatic exp_t e_idle(logic cr);
    exp_t r;
    r = '{wen: 1'b0, waddr: 12'h0, wdata: 32'h0, done: 1'b0, busy: 1'b0,
          trap_ready: 1'b1, csr_ready: cr};
    return r;
  endfunction

  function automatic exp_t e_wr(logic [11:0] a, logic [31:0] d, logic dn);
    exp_t r;
    r = '{wen: 1'b1, waddr: a, wdata: d, done: dn, busy: 1'b1,
          trap_ready: 1'b0, csr_ready: 1'b0};
    return r;
  endfunction

  function automatic exp_t e_empty_done();
    exp_t r;
    r = '{wen: 1'b0, waddr: 12'h0, wdata: 32'h0, done: 1'b1, busy: 1'b1,
          trap_ready: 1'b0, csr_ready: 1'b0};
    return r;
  endfunction

  function automatic vec_t v(in_t i, exp_t e);
    vec_t r;
    r.i = i;
    r.e = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic drive(input in_t i);
    i_trap_valid    = i.trap_valid;
    i_mepc_wen      = i.wens[0];
    i_mcause_wen    = i.wens[1];
    i_mstatus_wen   = i.wens[2];
    i_mepc_wdata    = i.mepc;
    i_mcause_wdata  = i.mcause;
    i_mstatus_wdata = i.mstatus;
    i_csr_valid     = i.csr_valid;
    i_csr_addr      = i.csr_addr;
    i_csr_wdata     = i.csr_wdata;
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".wen"},        32'(o_wen),        32'(e.wen));
    check({tag, ".waddr"},      32'(o_waddr),      32'(e.waddr));
    check({tag, ".wdata"},      o_wdata,           e.wdata);
    check({tag, ".done"},       32'(o_done),       32'(e.done));
    check({tag, ".busy"},       32'(o_busy),       32'(e.busy));
    check({tag, ".trap_ready"}, 32'(o_trap_ready), 32'(e.trap_ready));
    check({tag, ".csr_ready"},  32'(o_csr_ready),  32'(e.csr_ready));
  endtask

  // One cycle: drive at the falling edge, sample 1 ns later, accept happens on the next rising edge.
  task automatic apply_row(input string tag, input vec_t r);
    @(negedge i_clk);
    drive(r.i);
    #1;
    check_outs(tag, r.e);
  endtask

  initial begin
    logic [2:0] all_w;
    all_w = 3'b111;

    // case 1: full trap bundle
    tbl.push_back(v(mk_in(1, all_w, 32'h8000_0010, 32'hB, 32'h1800, 0, 12'h0, 32'h0), e_idle(1'b0)));
    tbl.push_back(v(in_idle(), e_wr(12'h341, 32'h8000_0010, 1'b0)));
    tbl.push_back(v(in_idle(), e_wr(12'h342, 32'h0000_000B, 1'b0)));
    tbl.push_back(v(in_idle(), e_wr(12'h300, 32'h0000_1800, 1'b1)));
    tbl.push_back(v(in_idle(), e_idle(1'b1)));
    // case 2: mcause only
    tbl.push_back(v(mk_in(1, 3'b010, 32'h0, 32'hB, 32'h0, 0, 12'h0, 32'h0), e_idle(1'b0)));
    tbl.push_back(v(in_idle(), e_wr(12'h342, 32'h0000_000B, 1'b1)));
    tbl.push_back(v(in_idle(), e_idle(1'b1)));
    // case 3: empty trap bundle
    tbl.push_back(v(mk_in(1, 3'b000, 32'h1, 32'h2, 32'h3, 0, 12'h0, 32'h0), e_idle(1'b0)));
    tbl.push_back(v(in_idle(), e_empty_done()));
    tbl.push_back(v(in_idle(), e_idle(1'b1)));
    // case 4: collision, csr held until trap sequence retires
    tbl.push_back(v(mk_in(1, 3'b101, 32'h200, 32'h0, 32'h88, 1, 12'h305, 32'h8000_0000), e_idle(1'b0)));
    tbl.push_back(v(mk_in(0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 12'h305, 32'h8000_0000),
                    e_wr(12'h341, 32'h200, 1'b0)));
    tbl.push_back(v(mk_in(0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 12'h305, 32'h8000_0000),
                    e_wr(12'h300, 32'h88, 1'b1)));
    tbl.push_back(v(mk_in(0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 12'h305, 32'h8000_0000), e_idle(1'b1)));
    tbl.push_back(v(in_idle(), e_wr(12'h305, 32'h8000_0000, 1'b1)));
    tbl.push_back(v(in_idle(), e_idle(1'b1)));
    // case 6: bundle changes after accept
    tbl.push_back(v(mk_in(1, all_w, 32'h1234, 32'h7, 32'h55, 0, 12'h0, 32'h0), e_idle(1'b0)));
    tbl.push_back(v(mk_in(0, all_w, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 0, 12'h0, 32'h0),
                    e_wr(12'h341, 32'h1234, 1'b0)));
    tbl.push_back(v(mk_in(0, 3'b000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 0, 12'h0, 32'h0),
                    e_wr(12'h342, 32'h7, 1'b0)));
    tbl.push_back(v(in_idle(), e_wr(12'h300, 32'h55, 1'b1)));
    // back-to-back csr then trap
    tbl.push_back(v(mk_in(0, 3'b000, 32'h0, 32'h0, 32'h0, 1, 12'h340, 32'h5A5A), e_idle(1'b1)));
    tbl.push_back(v(mk_in(1, 3'b010, 32'h0, 32'h2, 32'h0, 0, 12'h0, 32'h0), e_wr(12'h340, 32'h5A5A, 1'b1)));
    tbl.push_back(v(mk_in(1, 3'b010, 32'h0, 32'h2, 32'h0, 0, 12'h0, 32'h0), e_idle(1'b0)));
    tbl.push_back(v(in_idle(), e_wr(12'h342, 32'h2, 1'b1)));
    tbl.push_back(v(in_idle(), e_idle(1'b1)));

    // reset state
    i_rst_n = 1'b0;
    drive(in_idle());
    #1;
    check_outs("reset", e_idle(1'b1));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (tbl[k]) apply_row($sformatf("row%0d", k), tbl[k]);

    // case 5: reset during T+2 of a full trap sequence
    apply_row("rst.acc", v(mk_in(1, all_w, 32'h8000_0010, 32'hB, 32'h1800, 0, 12'h0, 32'h0), e_idle(1'b0)));
    apply_row("rst.t1", v(in_idle(), e_wr(12'h341, 32'h8000_0010, 1'b0)));
    apply_row("rst.t2", v(in_idle(), e_wr(12'h342, 32'h0000_000B, 1'b0)));
    #2;
    i_rst_n = 1'b0;
    #1;
    check_outs("rst.async", e_idle(1'b1));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) apply_row($sformatf("rst.quiet%0d", c), v(in_idle(), e_idle(1'b1)));
    apply_row("rst.new", v(mk_in(1, 3'b100, 32'h0, 32'h0, 32'h1800, 0, 12'h0, 32'h0), e_idle(1'b0)));
    apply_row("rst.new1", v(in_idle(), e_wr(12'h300, 32'h1800, 1'b1)));
    apply_row("rst.new2", v(in_idle(), e_idle(1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
